vga_fb_reader: RTL and testbench
================================

# vga_fb_reader

Pixel-fetch stage downstream of the 320x180 VGA timing generator. Converts the generator's scaled pixel coordinates into framebuffer read addresses, fetches 4-bit colour indices from an external synchronous RAM, maps them through a writable 16-entry palette, and drives registered 4:4:4 RGB plus sync delayed to match. Owns front/back buffer selection for tear-free double buffering, swapping only at the end of active drawing.

## Interface
- H_RES, 320, active pixels per line (scaled)
- V_RES, 180, active lines (scaled)
- ADDR_W, 16, address bits per buffer (57600 entries)
- IDX_W, 4, colour index width
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_pix_stb  in  1  pixel strobe; at most one every 2 i_clk
- i_x  in  10  scaled x, 0..319
- i_y  in  9  scaled y, 0..179
- i_active  in  1  active drawing
- i_hs, i_vs  in  1  sync from timing generator, active low
- i_animate  in  1  end-of-active-frame tick
- i_swap_req  in  1  level request to swap buffers
- o_swap_ack  out  1  one-clock pulse when swap taken
- o_front  out  1  current front (displayed) buffer
- o_rd_en  out  1  RAM read enable
- o_rd_addr  out  ADDR_W+1  {o_front, y*320+x}
- i_rd_data  in  IDX_W  RAM data, valid one i_clk after o_rd_en
- i_pal_we  in  1  palette write enable
- i_pal_addr  in  IDX_W  palette entry
- i_pal_data  in  12  {r,g,b} 4 bits each
- o_r, o_g, o_b  out  4 each  pixel colour
- o_hs, o_vs  out  1  sync delayed to match colour

## Operation
- Pipeline advances only on i_clk edges with i_pix_stb=1.
- S0 (strobe n): if i_active, o_rd_en=1 for that clock, o_rd_addr = {o_front, (i_y<<8)+(i_y<<6)+i_x}; else o_rd_en=0, address held. Active flag, i_hs, i_vs registered.
- i_rd_data captured one i_clk after o_rd_en into an index register.
- S1 (strobe n+1): palette read with captured index; active/sync shifted.
- S2 (strobe n+2): o_r/o_g/o_b = palette entry if delayed active, else 0; o_hs/o_vs = delayed syncs.
- Address arithmetic ADDR_W wide, no wrap for in-range inputs; no clamping.
- Swap: on a strobe with i_animate=1 and i_swap_req=1, o_front toggles and o_swap_ack pulses that clock. i_swap_req low at i_animate: no swap. Requester holds i_swap_req until ack and drops it the clock after.
- Palette: write on any clock with i_pal_we, independent of strobe. Same-clock write and S1 read of same entry returns old value.
- Reset (async, any time incl. mid-frame): o_r/o_g/o_b=0, o_hs=o_vs=1, o_rd_en=0, o_rd_addr=0, o_front=0, o_swap_ack=0, pipeline flags cleared, palette entry i = {i,i,i} (greyscale ramp).

## Timing
- Colour/sync latency: exactly 2 strobes from input sample to output update.
- RAM read latency: 1 i_clk; requires strobe spacing >= 2 i_clk.
- Swap effective for first address of next frame; buffer bit in o_rd_addr changes on the swap clock.
- o_swap_ack: high exactly one i_clk.
- Outputs change only on strobe clocks, except on reset.

## Structure
- Package vga_pkg: H_RES, V_RES, FB_DEPTH=57600, rgb444 typedef, default palette function.
- Sub-module vga_palette: 16x12 register file, one write port, one combinational read port, greyscale reset.

## Test plan
- Reset then x=0,y=0 active -> o_rd_addr=0x00000; x=319,y=179 -> 0x0E0FF; RGB appears 2 strobes later.
- RAM returns 5, palette default -> o_r=o_g=o_b=5; write entry 5 = 0xF00 -> next such pixel red 0xF,0,0.
- Inactive input -> o_rd_en=0, RGB 0 two strobes later; o_hs/o_vs equal inputs delayed 2 strobes.
- i_swap_req high mid-frame -> no change until i_animate strobe, then o_front 0->1, one-clock ack, next frame addresses have bit16=1.
- i_swap_req dropped before i_animate -> o_front unchanged, no ack.
- Async i_rst asserted mid-line -> RGB 0, syncs 1, o_front 0 immediately, palette back to greyscale.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer geometry, colour type and default palette.
package vga_pkg;
  localparam int H_RES = 320;
  localparam int V_RES = 180;
  localparam int FB_DEPTH = 57600;
  localparam int ADDR_W = 16;
  localparam int IDX_W = 4;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  function automatic rgb444_t default_pal(input logic [IDX_W-1:0] i);
    return '{r: i, g: i, b: i};
  endfunction
endpackage

// File: rtl/vga_palette.sv
// vga_palette: 16x12 colour register file, one write port, async read, greyscale reset.
module vga_palette
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  rgb444_t          i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output rgb444_t          o_rdata
);
  rgb444_t mem [2**IDX_W];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) for (int i = 0; i < 2**IDX_W; i++) mem[i] <= default_pal(IDX_W'(i));
    else if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: coordinate-to-address fetch, palette lookup and sync-aligned RGB output,
// with double-buffer front selection swapped only at end of active drawing.
module vga_fb_reader
  import vga_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  input  logic              i_active,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_animate,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_front,
  output logic              o_rd_en,
  output logic [ADDR_W:0]   o_rd_addr,
  input  logic [IDX_W-1:0]  i_rd_data,
  input  logic              i_pal_we,
  input  logic [IDX_W-1:0]  i_pal_addr,
  input  logic [11:0]       i_pal_data,
  output logic [3:0]        o_r,
  output logic [3:0]        o_g,
  output logic [3:0]        o_b,
  output logic              o_hs,
  output logic              o_vs
);
  logic swap, front_nxt, rd_pend;
  logic [1:0] act_d, hs_d, vs_d;
  logic [IDX_W-1:0] idx_q, idx_eff;
  logic [ADDR_W-1:0] pix_addr;
  rgb444_t pal_rd, pal_q;
  assign swap = i_pix_stb & i_animate & i_swap_req;
  assign front_nxt = o_front ^ swap;
  assign pix_addr = ADDR_W'({i_y, 8'b0}) + ADDR_W'({i_y, 6'b0}) + ADDR_W'(i_x);
  // RAM data lands the same clock a strobe may arrive, so bypass the index register then
  assign idx_eff = rd_pend ? i_rd_data : idx_q;
  vga_palette u_pal (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_pal_we),
    .i_waddr (i_pal_addr),
    .i_wdata (rgb444_t'(i_pal_data)),
    .i_raddr (idx_eff),
    .o_rdata (pal_rd)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_swap_ack <= 1'b0;
      o_front <= 1'b0;
      o_rd_en <= 1'b0;
      o_rd_addr <= '0;
      rd_pend <= 1'b0;
      idx_q <= '0;
    end else begin
      o_swap_ack <= swap;
      o_front <= front_nxt;
      o_rd_en <= i_pix_stb & i_active;
      rd_pend <= o_rd_en;
      if (rd_pend) idx_q <= i_rd_data;
      if (i_pix_stb) o_rd_addr <= {front_nxt, i_active ? pix_addr : o_rd_addr[ADDR_W-1:0]};
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      act_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
      pal_q <= '0;
      {o_r, o_g, o_b} <= '0;
      o_hs <= 1'b1;
      o_vs <= 1'b1;
    end else if (i_pix_stb) begin
      act_d <= {act_d[0], i_active};
      hs_d <= {hs_d[0], i_hs};
      vs_d <= {vs_d[0], i_vs};
      pal_q <= pal_rd;
      {o_r, o_g, o_b} <= act_d[1] ? pal_q : '0;
      o_hs <= hs_d[1];
      o_vs <= vs_d[1];
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed pixels with a scoreboard of expected RGB/sync two strobes out.
module tb_vga_fb_reader;
  import vga_pkg::*;
  logic i_clk = 1'b0, i_rst = 1'b1, i_pix_stb = 1'b0, i_active = 1'b0;
  logic i_hs = 1'b1, i_vs = 1'b1, i_animate = 1'b0, i_swap_req = 1'b0, i_pal_we = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic [3:0] i_rd_data = '0, i_pal_addr = '0;
  logic [11:0] i_pal_data = '0;
  logic o_swap_ack, o_front, o_rd_en, o_hs, o_vs;
  logic [16:0] o_rd_addr;
  logic [3:0] o_r, o_g, o_b;
  vga_fb_reader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
    .i_active(i_active), .i_hs(i_hs), .i_vs(i_vs), .i_animate(i_animate),
    .i_swap_req(i_swap_req), .o_swap_ack(o_swap_ack), .o_front(o_front),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr), .i_pal_data(i_pal_data),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hs(o_hs), .o_vs(o_vs)
  );
  always #5 i_clk = ~i_clk;
  logic [3:0] mem [0:131071];
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];
  typedef struct {
    int due;
    logic [11:0] rgb;
    logic hs;
    logic vs;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int stb_n = 0, pass_n = 0, total_n = 0;
  logic efront = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(posedge i_clk)
    if (i_pix_stb && !i_rst) begin
      stb_n++;
      #1;
      while (q.size() > 0 && q[0].due <= stb_n) begin
        e = q.pop_front();
        check("sb_due", e.due, stb_n);
        check("rgb", {o_r, o_g, o_b}, e.rgb);
        check("hs", o_hs, e.hs);
        check("vs", o_vs, e.vs);
      end
    end
  task automatic pix(input int x, input int y, input logic act, input logic hs, input logic vs,
                     input logic anim, input logic [11:0] rgb, input logic push = 1'b1,
                     input logic pwe = 1'b0, input logic [3:0] pa = 4'h0, input logic [11:0] pd = 12'h0);
    logic eack;
    logic [15:0] a;
    @(negedge i_clk);
    i_x = 10'(x); i_y = 9'(y); i_active = act; i_hs = hs; i_vs = vs; i_animate = anim;
    i_pal_we = pwe; i_pal_addr = pa; i_pal_data = pd; i_pix_stb = 1'b1;
    eack = anim & i_swap_req;
    efront ^= eack;
    a = 16'(y * 320 + x);
    if (push) q.push_back('{stb_n + 3, rgb, hs, vs});
    @(negedge i_clk);
    i_pix_stb = 1'b0; i_animate = 1'b0; i_pal_we = 1'b0;
    check("rd_en", o_rd_en, act);
    if (act) check("rd_addr", o_rd_addr, {efront, a});
    else check("buf_bit", o_rd_addr[16], efront);
    check("swap_ack", o_swap_ack, eack);
    check("front", o_front, efront);
    repeat (2) @(negedge i_clk);
    if (eack) check("ack_pulse", o_swap_ack, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 4'h0;
    mem[0] = 4'h5; mem[57599] = 4'h3; mem[322] = 4'h9; mem[65536] = 4'h7;
    repeat (3) @(negedge i_clk);
    check("rst_rgb", {o_r, o_g, o_b}, 12'h000);
    check("rst_hs", o_hs, 1'b1);
    check("rst_vs", o_vs, 1'b1);
    check("rst_front", o_front, 1'b0);
    check("rst_rd_en", o_rd_en, 1'b0);
    check("rst_addr", o_rd_addr, 17'h0);
    check("rst_ack", o_swap_ack, 1'b0);
    i_rst = 1'b0;
    pix(0, 0, 1, 1, 1, 0, 12'h555);
    pix(319, 179, 1, 1, 1, 0, 12'h333);
    pix(10, 0, 0, 0, 1, 0, 12'h000, 1, 1, 4'h3, 12'h0F0);
    pix(0, 0, 0, 1, 0, 0, 12'h000);
    pix(319, 179, 1, 1, 1, 0, 12'h0F0);
    @(negedge i_clk);
    i_pal_we = 1'b1; i_pal_addr = 4'h5; i_pal_data = 12'hF00;
    @(negedge i_clk);
    i_pal_we = 1'b0;
    pix(0, 0, 1, 1, 1, 0, 12'hF00);
    pix(2, 1, 1, 0, 0, 0, 12'h999);
    i_swap_req = 1'b1;
    pix(5, 5, 1, 1, 1, 0, 12'h000);
    pix(0, 0, 0, 1, 1, 1, 12'h000);
    i_swap_req = 1'b0;
    pix(0, 0, 1, 1, 1, 0, 12'h777);
    i_swap_req = 1'b1;
    pix(1, 1, 0, 1, 1, 0, 12'h000);
    i_swap_req = 1'b0;
    pix(0, 0, 0, 1, 1, 1, 12'h000);
    pix(0, 0, 1, 0, 0, 0, 12'h777);
    pix(0, 0, 1, 0, 0, 0, 12'h000, 0);
    pix(0, 0, 1, 0, 0, 0, 12'h000, 0);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    q.delete();
    efront = 1'b0;
    #1;
    check("arst_rgb", {o_r, o_g, o_b}, 12'h000);
    check("arst_hs", o_hs, 1'b1);
    check("arst_vs", o_vs, 1'b1);
    check("arst_front", o_front, 1'b0);
    check("arst_rd_en", o_rd_en, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    pix(0, 0, 1, 1, 1, 0, 12'h555);
    pix(319, 179, 1, 0, 1, 0, 12'h333);
    pix(0, 0, 0, 1, 1, 0, 12'h000, 0);
    pix(0, 0, 0, 1, 1, 0, 12'h000, 0);
    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
